imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the decode stage: extracts and

---
 rtl/imm_gen_pipe_pkg.sv | 21 ++
 rtl/imm_gen_pipe_extract.sv | 41 ++++
 rtl/imm_gen_pipe.sv | 103 ++++++++++
 tb/tb_imm_gen_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator:
// format codes, format-code width and queue state encoding.
package imm_gen_pipe_pkg;

  localparam int IMM_FMT_W = 3;

  localparam int IMM_FMT_R = 0;
  localparam int IMM_FMT_I = 1;
  localparam int IMM_FMT_S = 2;
  localparam int IMM_FMT_B = 3;
  localparam int IMM_FMT_U = 4;
  localparam int IMM_FMT_J = 5;
  localparam int IMM_FMT_Z = 6;

  typedef enum logic [1:0] {
    IMMQ_EMPTY = 2'd0,
    IMMQ_ONE   = 2'd1,
    IMMQ_FULL  = 2'd2
  } immq_state_t;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: picks the immediate bits of an RV
// instruction for the given format and sign/zero-extends them to XLEN.
// Unassigned format codes yield zero with the error flag set.
module imm_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FMT_W = IMM_FMT_W
) (
  input  logic [31:0]      instr,
  input  logic [FMT_W-1:0] fmt,
  output logic [XLEN-1:0]  imm,
  output logic             err
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Format decode and bit gathering; instr[31] is the sign for every signed format.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (fmt)
      FMT_W'(IMM_FMT_R): imm = '0;
      FMT_W'(IMM_FMT_I): imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
      FMT_W'(IMM_FMT_S): imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
      FMT_W'(IMM_FMT_B): imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                                instr[11:8], 1'b0};
      FMT_W'(IMM_FMT_U): imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      FMT_W'(IMM_FMT_J): imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                                instr[30:21], 1'b0};
      FMT_W'(IMM_FMT_Z): imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready on both sides.
// One output register plus one skid register give 1-cycle latency and
// an in_ready that depends only on the registered state.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FMT_W = IMM_FMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [FMT_W-1:0] in_fmt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err
);

  immq_state_t      state;
  immq_state_t      state_nxt;
  logic [XLEN-1:0]  new_imm;
  logic             new_err;
  logic [XLEN-1:0]  skid_imm;
  logic             skid_err;
  logic             accept;
  logic             pop;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  imm_extract #(
    .XLEN  (XLEN),
    .FMT_W (FMT_W)
  ) u_extract (
    .instr (in_instr),
    .fmt   (in_fmt),
    .imm   (new_imm),
    .err   (new_err)
  );

  // Occupancy state register; reset drops every held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IMMQ_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy transitions driven by the accept/pop handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      IMMQ_EMPTY: if (accept) state_nxt = IMMQ_ONE;
      IMMQ_ONE: begin
        if (accept && !pop)      state_nxt = IMMQ_FULL;
        else if (pop && !accept) state_nxt = IMMQ_EMPTY;
      end
      IMMQ_FULL: if (pop) state_nxt = IMMQ_ONE;
      default: state_nxt = IMMQ_EMPTY;
    endcase
  end

  // Handshakes and data-register load enables, all derived from the state.
  always_comb begin
    in_ready      = (state != IMMQ_FULL);
    out_valid     = (state != IMMQ_EMPTY);
    accept        = in_valid && in_ready;
    pop           = out_valid && out_ready;
    load_out_new  = accept && ((state == IMMQ_EMPTY) || ((state == IMMQ_ONE) && pop));
    load_skid     = accept && (state == IMMQ_ONE) && !pop;
    load_out_skid = (state == IMMQ_FULL) && pop;
  end

  // Output register: new entry when it can go straight out, else refill from skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm <= '0;
      out_err <= 1'b0;
    end else if (load_out_new) begin
      out_imm <= new_imm;
      out_err <= new_err;
    end else if (load_out_skid) begin
      out_imm <= skid_imm;
      out_err <= skid_err;
    end
  end

  // Skid register catches an entry accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm <= '0;
      skid_err <= 1'b0;
    end else if (load_skid) begin
      skid_imm <= new_imm;
      skid_err <= new_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance
// share the same stimulus; expected immediates come from an arithmetic model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_fmt = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[11];
  int          nChecks = 0;
  int          nFails = 0;
  bit          rdyRandom = 1'b0;
  bit          stallPrev = 1'b0;
  logic [31:0] prevImm32;
  logic [63:0] prevImm64;
  logic        prevErr32, prevErr64;

  imm_gen_pipe #(.XLEN(32), .FMT_W(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .FMT_W(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_err(out_err64)
  );

  always #5 clk = ~clk;

  // Reference: immediate value as a signed 64-bit number built by arithmetic.
  function automatic logic [63:0] refImm(input logic [31:0] ins, input int fmt,
                                         output logic err);
    longint s;
    longint r;
    s   = longint'($signed(ins));
    r   = 0;
    err = 1'b0;
    case (fmt)
      0: r = 0;
      1: r = s >>> 20;
      2: r = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3: r = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
             | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      4: r = s & 64'hFFFF_FFFF_FFFF_F000;
      5: r = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
             | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      6: r = longint'(ins[19:15]);
      default: begin
        r   = 0;
        err = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction from posedge+1 until accepted, then queue its expectation.
  task automatic applyStimulus(input logic [31:0] instr, input logic [2:0] fmt,
                               input logic [31:0] e32, input logic [63:0] e64,
                               input logic err);
    exp_t e;
    int   waitCycles;
    bit   accepted;
    waitCycles = 0;
    accepted   = 1'b0;
    in_valid   = 1'b1;
    in_instr   = instr;
    in_fmt     = fmt;
    while (!accepted && waitCycles < 200) begin
      @(negedge clk);
      if (in_ready32) begin
        accepted = 1'b1;
        checkOutput("in_ready64", {63'd0, in_ready64}, 64'd1);
        e.e32 = e32;
        e.e64 = e64;
        e.err = err;
        sbq.push_back(e);
      end else begin
        waitCycles++;
      end
    end
    if (!accepted) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = $urandom;
    in_fmt   = 3'($urandom_range(0, 7));
  endtask

  task automatic waitDrain(input int limit);
    int c;
    c = 0;
    while (sbq.size() != 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (sbq.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output handshake and checks held values under stall.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stallPrev = 1'b0;
      end else begin
        if (stallPrev) begin
          checkOutput("hold_imm32", {32'd0, out_imm32}, {32'd0, prevImm32});
          checkOutput("hold_imm64", out_imm64, prevImm64);
          checkOutput("hold_err", {62'd0, out_err32, out_err64}, {62'd0, prevErr32, prevErr64});
        end
        if (out_valid32 && out_ready) begin
          if (sbq.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected_output: got out_valid=1 imm %h expected no output",
                     out_imm32);
          end else begin
            e = sbq.pop_front();
            checkOutput("out_valid64", {63'd0, out_valid64}, 64'd1);
            checkOutput("imm32", {32'd0, out_imm32}, {32'd0, e.e32});
            checkOutput("imm64", out_imm64, e.e64);
            checkOutput("err32", {63'd0, out_err32}, {63'd0, e.err});
            checkOutput("err64", {63'd0, out_err64}, {63'd0, e.err});
          end
        end
        stallPrev = out_valid32 && !out_ready;
        prevImm32 = out_imm32;
        prevImm64 = out_imm64;
        prevErr32 = out_err32;
        prevErr64 = out_err64;
      end
    end
  end

  // Random consumer readiness during the stress phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdyRandom) out_ready = ($urandom_range(0, 99) < 70);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no end of test expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] r;
    logic        rerr;
    logic [31:0] ins;
    int          f;

    // Expected values below are derived by hand from the immediate bit layouts.
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'hFE000FE3, 3'd3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    vecs[3]  = '{32'hFE20AC23, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[4]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[5]  = '{32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[7]  = '{32'hFFFFFFFF, 3'd0, 32'h00000000, 64'h0000000000000000, 1'b0};
    vecs[8]  = '{32'h000FD073, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[9]  = '{32'h0001F073, 3'd6, 32'h00000003, 64'h0000000000000003, 1'b0};
    vecs[10] = '{32'hFF9FF06F, 3'd5, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};

    // Reset state
    #2;
    checkOutput("rst_out_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
    checkOutput("rst_in_ready", {62'd0, in_ready32, in_ready64}, 64'd3);
    checkOutput("rst_imm", out_imm64 | {32'd0, out_imm32}, 64'd0);
    checkOutput("rst_err", {62'd0, out_err32, out_err64}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors with a ready consumer
    $display("[TB] directed vectors");
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].instr, vecs[i].fmt, vecs[i].e32, vecs[i].e64, vecs[i].err);
    waitDrain(20);

    // Backpressure: two fill the pipe, third must wait
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(vecs[0].instr, vecs[0].fmt, vecs[0].e32, vecs[0].e64, vecs[0].err);
    applyStimulus(vecs[4].instr, vecs[4].fmt, vecs[4].e32, vecs[4].e64, vecs[4].err);
    in_valid = 1'b1;
    in_instr = vecs[3].instr;
    in_fmt   = vecs[3].fmt;
    repeat (2) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {62'd0, in_ready32, in_ready64}, 64'd0);
      checkOutput("bp_out_valid", {62'd0, out_valid32, out_valid64}, 64'd3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(vecs[3].instr, vecs[3].fmt, vecs[3].e32, vecs[3].e64, vecs[3].err);
    waitDrain(20);

    // Asynchronous reset while full
    $display("[TB] reset while full");
    out_ready = 1'b0;
    applyStimulus(vecs[1].instr, vecs[1].fmt, vecs[1].e32, vecs[1].e64, vecs[1].err);
    applyStimulus(vecs[2].instr, vecs[2].fmt, vecs[2].e32, vecs[2].e64, vecs[2].err);
    #2;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    checkOutput("arst_out_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
    checkOutput("arst_in_ready", {62'd0, in_ready32, in_ready64}, 64'd3);
    checkOutput("arst_imm", out_imm64 | {32'd0, out_imm32}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_rst_no_output", {62'd0, out_valid32, out_valid64}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Random stress against the arithmetic model
    $display("[TB] random stress");
    rdyRandom = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        @(posedge clk);
        #1;
      end
      ins = $urandom;
      f   = $urandom_range(0, 7);
      r   = refImm(ins, f, rerr);
      applyStimulus(ins, 3'(f), r[31:0], r, rerr);
    end
    rdyRandom = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
